// File: rtl/dma_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_arb_pkg
// Description : Shared types and helpers for the DMA channel arbiter.
//               - arbState_t : one-hot arbiter FSM state encoding
//               - MAX_CH     : largest supported channel count
//               - fixedOrder : builds the reset/fixed priority order
//               - rotateOrder: moves the granted channel to the lowest-priority
//                              slot and shifts the others toward slot 0
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dma_arb_pkg;

  localparam int MAX_CH    = 8;
  localparam int MAX_CH_W  = 3;
  localparam int MAX_ORD_W = MAX_CH * MAX_CH_W;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_REQUEST = 4'b0010,
    ST_GRANT   = 4'b0100,
    ST_RELEASE = 4'b1000
  } arbState_t;

  // Slot s holds channel s; slot 0 (LSBs) is the highest priority.
  function automatic logic [MAX_ORD_W-1:0] fixedOrder(input int numCh, input int chW);
    logic [MAX_ORD_W-1:0] res;
    res = '0;
    for (int s = 0; s < MAX_CH; s++) begin
      if (s < numCh) res = res | (MAX_ORD_W'(s) << (s * chW));
    end
    return res;
  endfunction

  // Granted channel drops to slot numCh-1; every channel that sat above it in
  // priority keeps its slot, every channel below it moves up by one slot.
  function automatic logic [MAX_ORD_W-1:0] rotateOrder(
    input logic [MAX_ORD_W-1:0] order,
    input logic [MAX_CH_W-1:0]  granted,
    input int                   numCh,
    input int                   chW
  );
    logic [MAX_ORD_W-1:0] res;
    logic [MAX_ORD_W-1:0] mask;
    logic [MAX_CH_W-1:0]  cur;
    logic [MAX_CH_W-1:0]  nxt;
    logic                 seen;
    res  = '0;
    mask = MAX_ORD_W'((1 << chW) - 1);
    seen = 1'b0;
    for (int s = 0; s < MAX_CH; s++) begin
      cur = MAX_CH_W'((order >> (s * chW)) & mask);
      nxt = MAX_CH_W'((order >> ((s + 1) * chW)) & mask);
      if (s < numCh - 1) begin
        if (cur == granted) seen = 1'b1;
        res = res | (MAX_ORD_W'(seen ? nxt : cur) << (s * chW));
      end else if (s == numCh - 1) begin
        res = res | (MAX_ORD_W'(granted) << (s * chW));
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_priority_resolver.sv
`default_nettype none
// ============================================================================
// Module      : dma_priority_resolver
// Description : Combinational winner selection. Walks the priority order from
//               slot 0 upward and returns the first channel with a request.
// Ports       : effReq_i        - effective per-channel requests
//               priorityOrder_i - packed order, slot 0 in the LSBs
//               winner_o        - index of the selected channel
//               anyReq_o        - at least one request is pending
// Revision    : 1.0 - initial release
// ============================================================================
module dma_priority_resolver
  import dma_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0]      effReq_i,
  input  logic [NUM_CH*CH_W-1:0] priorityOrder_i,
  output logic [CH_W-1:0]        winner_o,
  output logic                   anyReq_o
);

  logic [CH_W-1:0] slotCh;
  logic            found;

  always_comb begin
    winner_o = '0;
    slotCh   = '0;
    found    = 1'b0;
    for (int s = 0; s < NUM_CH; s++) begin
      slotCh = CH_W'(priorityOrder_i >> (s * CH_W));
      if (!found && effReq_i[slotCh]) begin
        winner_o = slotCh;
        found    = 1'b1;
      end
    end
    anyReq_o = |effReq_i;
  end

endmodule
`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_priority_arbiter
// Description : DMA channel arbiter and hold-handshake engine. Raises HRQ on
//               any effective request, grants one channel per HLDA cycle,
//               releases on transfer end / EOP and optionally rotates priority.
//               A sticky watchdog flags an HLDA that takes too long.
// Ports       : CLK, RESET_N          - clock, async active-low reset
//               DREQ, dreqSenseLow    - hardware requests and their polarity
//               maskReg, swRequest    - channel masks, software requests
//               priorityType          - 0 fixed, 1 rotating
//               ctrlDisable           - blocks all requests
//               HLDA, transferDone, EOP_N - bus/timing handshakes
//               HRQ, DACK, dackSenseHigh  - hold request, acknowledges
//               activeChannel, grantValid - current grant
//               holdTimeout           - sticky watchdog flag
//               priorityOrder         - current order, slot 0 highest
// Revision    : 1.0 - initial release
// ============================================================================
module dma_priority_arbiter
  import dma_arb_pkg::*;
#(
  parameter  int NUM_CH       = 4,
  parameter  int HOLD_TIMEOUT = 255,
  localparam int CH_W         = $clog2(NUM_CH)
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [NUM_CH-1:0]      DREQ,
  input  logic                   dreqSenseLow,
  input  logic                   dackSenseHigh,
  input  logic                   priorityType,
  input  logic                   ctrlDisable,
  input  logic [NUM_CH-1:0]      maskReg,
  input  logic [NUM_CH-1:0]      swRequest,
  input  logic                   HLDA,
  input  logic                   transferDone,
  input  logic                   EOP_N,
  output logic                   HRQ,
  output logic [NUM_CH-1:0]      DACK,
  output logic [CH_W-1:0]        activeChannel,
  output logic                   grantValid,
  output logic                   holdTimeout,
  output logic [NUM_CH*CH_W-1:0] priorityOrder
);

  localparam int                   ORD_W       = NUM_CH * CH_W;
  localparam int                   WD_W        = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [WD_W-1:0]      WD_MAX      = WD_W'(HOLD_TIMEOUT);
  localparam logic [ORD_W-1:0]     FIXED_ORDER = ORD_W'(fixedOrder(NUM_CH, CH_W));

  arbState_t           state_q;
  logic                hrq_q;
  logic [NUM_CH-1:0]   dack_q;          // active-high one-hot; polarity applied at the pin
  logic [CH_W-1:0]     activeChannel_q;
  logic                grantValid_q;
  logic                holdTimeout_q;
  logic [WD_W-1:0]     wdCnt_q;
  logic [ORD_W-1:0]    order_q;

  logic [NUM_CH-1:0]   effReq;
  logic [CH_W-1:0]     winner;
  logic                anyReq;
  logic [NUM_CH-1:0]   winnerOneHot;
  logic [WD_W-1:0]     wdNext;
  logic [ORD_W-1:0]    rotated;

  always_comb begin
    effReq = '0;
    if (!ctrlDisable) effReq = ((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | swRequest;
  end

  dma_priority_resolver #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_resolver (
    .effReq_i        (effReq),
    .priorityOrder_i (order_q),
    .winner_o        (winner),
    .anyReq_o        (anyReq)
  );

  assign winnerOneHot = NUM_CH'(1) << winner;
  assign wdNext       = (wdCnt_q == WD_MAX) ? wdCnt_q : wdCnt_q + WD_W'(1);
  assign rotated      = ORD_W'(rotateOrder(MAX_ORD_W'(order_q), MAX_CH_W'(activeChannel_q),
                                           NUM_CH, CH_W));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q         <= ST_IDLE;
      hrq_q           <= 1'b0;
      dack_q          <= '0;
      activeChannel_q <= '0;
      grantValid_q    <= 1'b0;
      holdTimeout_q   <= 1'b0;
      wdCnt_q         <= '0;
      order_q         <= FIXED_ORDER;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (anyReq) begin
            state_q <= ST_REQUEST;
            hrq_q   <= 1'b1;
            wdCnt_q <= '0;
          end
        end
        ST_REQUEST: begin
          // Watchdog keeps counting on the granting edge too; the flag is
          // only informational and never aborts the hold request.
          wdCnt_q <= wdNext;
          if (wdNext == WD_MAX) holdTimeout_q <= 1'b1;
          if (HLDA) begin
            if (anyReq) begin
              state_q         <= ST_GRANT;
              dack_q          <= winnerOneHot;
              activeChannel_q <= winner;
              grantValid_q    <= 1'b1;
            end else begin
              state_q <= ST_RELEASE;
              hrq_q   <= 1'b0;
            end
          end
        end
        ST_GRANT: begin
          if (transferDone || !EOP_N) begin
            state_q      <= ST_RELEASE;
            hrq_q        <= 1'b0;
            dack_q       <= '0;
            grantValid_q <= 1'b0;
            if (priorityType) order_q <= rotated;
          end
        end
        ST_RELEASE: begin
          if (!HLDA) state_q <= ST_IDLE;
        end
        default: begin
          state_q      <= ST_IDLE;
          hrq_q        <= 1'b0;
          dack_q       <= '0;
          grantValid_q <= 1'b0;
        end
      endcase
      // Fixed mode always reasserts the natural order, which also restores it
      // one edge after rotating mode is switched off.
      if (!priorityType) order_q <= FIXED_ORDER;
    end
  end

  assign HRQ           = hrq_q;
  assign DACK          = dackSenseHigh ? dack_q : ~dack_q;
  assign activeChannel = activeChannel_q;
  assign grantValid    = grantValid_q;
  assign holdTimeout   = holdTimeout_q;
  assign priorityOrder = order_q;

endmodule
`default_nettype wire

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Parametrised channel arbiter and hold-handshake engine for the DMA controller, generalising the 4-channel fixed/rotating priority logic to NUM_CH channels.
- Adds per-channel masking, software requests, programmable DREQ/DACK polarity, one-transfer-per-grant sequencing and a hold-acknowledge watchdog.
- Sits between the bus interface (DREQ, HLDA, HRQ, DACK) and the timing-control FSM, which reports transfer completion.

Parameters:
- NUM_CH, 4, number of DMA channels; legal range 2..8.
- CH_W, $clog2(NUM_CH), width of a channel index (derived, not overridden).
- HOLD_TIMEOUT, 255, cycles allowed in REQUEST before holdTimeout sets; minimum 1.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- DREQ  in  NUM_CH  hardware DMA requests.
- dreqSenseLow  in  1  when 1, DREQ is active-low.
- dackSenseHigh  in  1  when 1, DACK is active-high; when 0, active-low.
- priorityType  in  1  0 = fixed, 1 = rotating.
- ctrlDisable  in  1  command-register controller disable.
- maskReg  in  NUM_CH  1 = channel masked.
- swRequest  in  NUM_CH  software request bits, active-high, not maskable.
- HLDA  in  1  hold acknowledge from CPU.
- transferDone  in  1  one-cycle pulse from timing control at end of a transfer (S4).
- EOP_N  in  1  external end-of-process, active-low.
- HRQ  out  1  hold request.
- DACK  out  NUM_CH  channel acknowledge, polarity per dackSenseHigh.
- activeChannel  out  CH_W  index of the granted channel.
- grantValid  out  1  high while in GRANT.
- holdTimeout  out  1  sticky watchdog flag.
- priorityOrder  out  NUM_CH*CH_W  current order; slot 0 (LSBs) holds the highest-priority channel.

Behaviour:
- Reset (async, RESET_N low):
  - State IDLE; HRQ = 0, grantValid = 0, activeChannel = 0, holdTimeout = 0.
  - DACK = all inactive: 0 if dackSenseHigh, else all ones.
  - priorityOrder = {N-1,...,1,0}; for N = 4 this is 8'b11_10_01_00.
  - Reset asserted mid-transfer aborts immediately; no rotation is applied.
- Effective request: effReq[i] = ((DREQ[i] ^ dreqSenseLow) & ~maskReg[i]) | swRequest[i]. Forced to 0 when ctrlDisable = 1.
- FSM states: IDLE, REQUEST, GRANT, RELEASE.
  - IDLE: if |effReq, go to REQUEST and HRQ = 1 on the next edge (1-cycle latency).
  - REQUEST: HRQ held at 1; watchdog counter increments each cycle.
    - If HLDA = 1 and |effReq: the winner is the first channel in priorityOrder with effReq set, sampled on this edge. Go to GRANT; DACK[winner], activeChannel and grantValid update on the same edge. DACK therefore appears 1 cycle after HLDA is sampled high.
    - If HLDA = 1 and effReq = 0: go to RELEASE with no DACK.
    - If HLDA = 0 and effReq drops to 0: stay in REQUEST (HRQ cannot be withdrawn before HLDA).
    - When the counter reaches HOLD_TIMEOUT: holdTimeout sets and stays set until reset; the FSM keeps waiting.
  - GRANT: DACK and activeChannel held stable. A DREQ change does not re-arbitrate.
    - transferDone = 1 or EOP_N = 0: go to RELEASE; DACK goes inactive and grantValid = 0 on that edge.
    - If both occur in the same cycle, it is treated as a single end.
    - In rotating mode the granted channel moves to the lowest slot on the same edge; the others shift up preserving relative order.
  - RELEASE: HRQ = 0. Go to IDLE when HLDA = 0. A new request is never raised while HLDA is still high.
- Priority order updates:
  - priorityType changing 1 -> 0 restores the fixed order on the next edge.
  - The order is not modified outside the GRANT -> RELEASE transition.
- Watchdog: counter clears on entry to REQUEST; width $clog2(HOLD_TIMEOUT+1); saturates at HOLD_TIMEOUT.
- Invariants:
  - At most one DACK is active at any time.
  - DACK is active only while grantValid = 1.
  - HRQ = 1 in REQUEST and GRANT only.

Decomposition:
- Shared package dma_arb_pkg holds:
  - the state enum arbState_t (one-hot, 4 bits);
  - MAX_CH = 8;
  - function rotateOrder(order, granted) implementing the move-to-bottom rotation.
- One sub-module, dma_priority_resolver: purely combinational; inputs effReq and priorityOrder; outputs winner index and anyReq.
- The FSM, watchdog, order register and output registers stay in the top module.

Test Plan:
- Reset: assert RESET_N = 0 mid-GRANT -> DACK = 0000 immediately (dackSenseHigh = 1), HRQ = 0, priorityOrder = 8'b11_10_01_00.
- Fixed priority: NUM_CH = 4, DREQ = 4'b1010, HLDA high 2 cycles after HRQ -> DACK = 4'b0010 one cycle after HLDA sampled; transferDone -> DACK = 0, then HRQ = 0.
- Rotating priority: DREQ = 4'b1111 held, four grant cycles -> DACK sequence 0001, 0010, 0100, 1000; priorityOrder after the first grant = 8'b00_11_10_01.
- Masking and software request: maskReg = 4'b0001, DREQ = 4'b0001, swRequest = 4'b0100 -> DACK = 4'b0100; with swRequest = 0 -> HRQ stays 0.
- Polarity and EOP: dreqSenseLow = 1, dackSenseHigh = 0, DREQ = 4'b0111 -> DACK = 4'b0111 (channel 3 granted); EOP_N = 0 in GRANT -> DACK = 4'b1111 on the next edge.
- Watchdog, NUM_CH = 8, HOLD_TIMEOUT = 10: DREQ[5] high, HLDA held 0 -> holdTimeout = 1 exactly 10 cycles after REQUEST entry; a later HLDA then grants DACK = 8'b0010_0000.
